control_unit_fft_iter_gen: RTL and testbench

CONTROL_UNIT_FFT_ITER_GEN -- requirements
Module: control_unit_fft_iter_gen

---
 rtl/control_unit_fft_iter_gen.sv | 163 ++++++++++++++++
 tb/tb_control_unit_fft_iter_gen.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/control_unit_fft_iter_gen.sv
// -----------------------------------------------------------------------------
// control_unit_fft_iter_gen
//
// Sequencer for an iterative in-place FFT engine. A transform is LAYERS layers
// of BUTTERFLYES butterflies. Each butterfly takes BUT_CYC = 4/BUT_MUL_COUNT
// cycles. After the last butterfly of a layer the unit waits PIPE_LAT cycles
// for the datapath to drain, then advances the layer.
//
// Ports
//   CLK        sole clock, rising edge
//   RST        asynchronous active-low reset
//   EN         global enable; 0 freezes all state and masks the strobes
//   START      transform request, only looked at while idle
//   BUT_STROB  butterfly-start strobe (phase 0 of each butterfly)
//   LAY_EN     layer-advance pulse (last drain cycle of a layer)
//   ADDR_EN    address-generator advance (last phase of each butterfly)
//   Wr         result-memory write enable, ADDR_EN delayed PIPE_LAT cycles
//   FIRST      high while layer 0 is being processed
//   BUSY       high from the first RUN cycle through the final write
//   DONE       one-cycle pulse on the final write of a transform
//   LAYER      current layer index
//   BUTT       current butterfly index
// -----------------------------------------------------------------------------
module control_unit_fft_iter_gen #(
  parameter int LAYERS        = 5,
  parameter int BUTTERFLYES   = 16,
  parameter int LayWL         = 3,
  parameter int ButtWL        = 4,
  parameter int BUT_MUL_COUNT = 1,
  parameter int PIPE_LAT      = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic              START,
  output logic              BUT_STROB,
  output logic              LAY_EN,
  output logic              ADDR_EN,
  output logic              Wr,
  output logic              FIRST,
  output logic              BUSY,
  output logic              DONE,
  output logic [LayWL-1:0]  LAYER,
  output logic [ButtWL-1:0] BUTT
);

  localparam int BUT_CYC = 4 / BUT_MUL_COUNT;
  localparam int FC_W    = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  generate
    if (BUT_MUL_COUNT != 1 && BUT_MUL_COUNT != 2 && BUT_MUL_COUNT != 4) begin : g_bad_mul
      $error("control_unit_fft_iter_gen: BUT_MUL_COUNT must be 1, 2 or 4");
    end
    if (PIPE_LAT < 1) begin : g_bad_lat
      $error("control_unit_fft_iter_gen: PIPE_LAT must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t              state;
  logic [1:0]          ph;      // phase within a butterfly, 0..BUT_CYC-1
  logic [FC_W-1:0]     fcnt;    // drain-cycle counter in FLUSH
  logic [ButtWL-1:0]   butt;
  logic [LayWL-1:0]    layer;
  logic [PIPE_LAT-1:0] dline;   // ADDR_EN history; the oldest bit drives Wr

  logic ph_first;
  logic ph_last;
  logic butt_last;
  logic layer_last;
  logic strob_int;
  logic addr_int;
  logic lay_int;

  // Internal (ungated) decodes of registered state. EN only masks the pulses
  // at the outputs, so the strobes never see START combinationally.
  assign ph_first   = (ph == 2'd0);
  assign ph_last    = (ph == 2'(BUT_CYC - 1));
  assign butt_last  = (butt == ButtWL'(BUTTERFLYES - 1));
  assign layer_last = (layer == LayWL'(LAYERS - 1));
  assign strob_int  = (state == S_RUN) && ph_first;
  assign addr_int   = (state == S_RUN) && ph_last;
  assign lay_int    = (state == S_FLUSH) && (fcnt == FC_W'(PIPE_LAT - 1));

  assign BUT_STROB = EN && strob_int;
  assign ADDR_EN   = EN && addr_int;
  assign Wr        = EN && dline[PIPE_LAT-1];
  assign LAY_EN    = EN && lay_int;
  assign DONE      = EN && lay_int && layer_last;
  assign BUSY      = (state != S_IDLE);
  assign FIRST     = BUSY && (layer == '0);
  assign LAYER     = layer;
  assign BUTT      = butt;

  // NOTE: every register here uses non-blocking assignments so all updates in
  // one edge read the pre-edge values; blocking ones would make the delay
  // line collapse into a single stage.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= S_IDLE;
      ph    <= '0;
      fcnt  <= '0;
      butt  <= '0;
      layer <= '0;
      dline <= '0;
    end else if (EN) begin
      dline[0] <= addr_int;
      for (int i = 1; i < PIPE_LAT; i++) begin
        dline[i] <= dline[i-1];
      end

      case (state)
        S_IDLE: begin
          if (START) begin
            state <= S_RUN;
            ph    <= '0;
            butt  <= '0;
          end
        end

        S_RUN: begin
          if (ph_last) begin
            ph <= '0;
            if (butt_last) begin
              butt  <= '0;
              fcnt  <= '0;
              state <= S_FLUSH;
            end else begin
              butt <= butt + ButtWL'(1);
            end
          end else begin
            ph <= ph + 2'd1;
          end
        end

        S_FLUSH: begin
          if (lay_int) begin
            fcnt <= '0;
            if (layer_last) begin
              layer <= '0;
              state <= S_IDLE;
            end else begin
              layer <= layer + LayWL'(1);
              ph    <= '0;
              butt  <= '0;
              state <= S_RUN;
            end
          end else begin
            fcnt <= fcnt + FC_W'(1);
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit_fft_iter_gen.sv
// -----------------------------------------------------------------------------
// tb_control_unit_fft_iter_gen
//
// Directed bench. Two instances share the clock and inputs: dut_a uses four
// multipliers (one cycle per butterfly), dut_b one multiplier (four cycles per
// butterfly); both run 2 layers x 2 butterflies with a 2-cycle pipeline.
// Each scenario is a table of per-cycle input masks and hand-derived
// per-cycle expected output masks (bit k = cycle k, cycle 0 = START cycle).
// -----------------------------------------------------------------------------
module tb_control_unit_fft_iter_gen;

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  logic start;

  logic       a_strob, a_lay, a_addr, a_wr, a_first, a_busy, a_done;
  logic [2:0] a_layer;
  logic [3:0] a_butt;
  logic       b_strob, b_lay, b_addr, b_wr, b_first, b_busy, b_done;
  logic [2:0] b_layer;
  logic [3:0] b_butt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  control_unit_fft_iter_gen #(
    .LAYERS(2), .BUTTERFLYES(2), .LayWL(3), .ButtWL(4),
    .BUT_MUL_COUNT(4), .PIPE_LAT(2)
  ) dut_a (
    .CLK(clk), .RST(rst_n), .EN(en), .START(start),
    .BUT_STROB(a_strob), .LAY_EN(a_lay), .ADDR_EN(a_addr), .Wr(a_wr),
    .FIRST(a_first), .BUSY(a_busy), .DONE(a_done),
    .LAYER(a_layer), .BUTT(a_butt)
  );

  control_unit_fft_iter_gen #(
    .LAYERS(2), .BUTTERFLYES(2), .LayWL(3), .ButtWL(4),
    .BUT_MUL_COUNT(1), .PIPE_LAT(2)
  ) dut_b (
    .CLK(clk), .RST(rst_n), .EN(en), .START(start),
    .BUT_STROB(b_strob), .LAY_EN(b_lay), .ADDR_EN(b_addr), .Wr(b_wr),
    .FIRST(b_first), .BUSY(b_busy), .DONE(b_done),
    .LAYER(b_layer), .BUTT(b_butt)
  );

  typedef struct {
    int          n;
    logic [31:0] start, en_off, rst;
    logic [31:0] strob, addr, wr, lay, first, busy, done, layer1, butt1;
  } scen_t;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Observation vector: {strob, addr, wr, lay, first, busy, done, layer, butt}
  function automatic logic [31:0] obs(input bit sel);
    if (sel)
      return 32'({b_strob, b_addr, b_wr, b_lay, b_first, b_busy, b_done, b_layer, b_butt});
    else
      return 32'({a_strob, a_addr, a_wr, a_lay, a_first, a_busy, a_done, a_layer, a_butt});
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0;
    start = 1'b0;
    en    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_a", obs(1'b0), 32'd0);
    check("reset_b", obs(1'b1), 32'd0);
  endtask

  task automatic run_scen(input string name, input bit sel, input scen_t s);
    logic [31:0] exp;
    for (int k = 0; k < s.n; k++) begin
      @(posedge clk);
      #1;
      start = s.start[k];
      en    = !s.en_off[k];
      rst_n = !s.rst[k];
      #1;
      exp = 32'({s.strob[k], s.addr[k], s.wr[k], s.lay[k], s.first[k],
                 s.busy[k], s.done[k], 3'(s.layer1[k]), 4'(s.butt1[k])});
      check($sformatf("%s@%0d", name, k), obs(sel), exp);
    end
    start = 1'b0;
    en    = 1'b1;
  endtask

  initial begin
    scen_t s;

    // Basic timeline, one cycle per butterfly.
    apply_reset();
    s = '{n: 12, start: 32'h1, en_off: 32'h0, rst: 32'h0,
          strob: 32'h66, addr: 32'h66, wr: 32'h198, lay: 32'h110,
          first: 32'h1E, busy: 32'h1FE, done: 32'h100,
          layer1: 32'h1E0, butt1: 32'h44};
    run_scen("base", 1'b0, s);

    // START repeated while busy must change nothing.
    apply_reset();
    s.start = 32'h49;
    run_scen("restart_ignored", 1'b0, s);

    // EN low for cycles 2..4: gap, then everything shifted by 3.
    apply_reset();
    s = '{n: 14, start: 32'h1, en_off: 32'h1C, rst: 32'h0,
          strob: 32'h322, addr: 32'h322, wr: 32'hCC0, lay: 32'h880,
          first: 32'hFE, busy: 32'hFFE, done: 32'h800,
          layer1: 32'hF00, butt1: 32'h23C};
    run_scen("en_gap", 1'b0, s);

    // Reset during cycles 6..7 abandons the transform; START in the release
    // cycle 8 replays the base timeline shifted by 8.
    apply_reset();
    s = '{n: 19, start: 32'h101, en_off: 32'h0, rst: 32'hC0,
          strob: 32'h6626, addr: 32'h6626, wr: 32'h19818, lay: 32'h11010,
          first: 32'h1E1E, busy: 32'h1FE3E, done: 32'h10000,
          layer1: 32'h1E020, butt1: 32'h4404};
    run_scen("mid_reset", 1'b0, s);

    // Four cycles per butterfly: ADDR_EN three cycles after BUT_STROB, DONE at 20.
    apply_reset();
    s = '{n: 23, start: 32'h1, en_off: 32'h0, rst: 32'h0,
          strob: 32'h8822, addr: 32'h44110, wr: 32'h110440, lay: 32'h100400,
          first: 32'h7FE, busy: 32'h1FFFFE, done: 32'h100000,
          layer1: 32'h1FF800, butt1: 32'h781E0};
    run_scen("four_cyc", 1'b1, s);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
